// File: rtl/speck_round_scheduler.sv
// ---------------------------------------------------------------------------
// speck_round_scheduler
//
// Iterative SPECK128/128 encryption controller. It drives one external
// single-round unit through a start/finished handshake for ROUNDS rounds.
// The key is expanded on the fly, one 64-bit subkey per round. Each round's
// result is fed back as the next round's input block.
//
// Parameters
//   ROUNDS            rounds per block, legal range 1..32 (default 32)
//
// Ports
//   clk               sole clock, rising edge
//   rst               asynchronous, active-high reset
//   start             host request, sampled only while idle
//   key               {l0, k0}; k0 = key[63:0] is the round-0 subkey
//   plaintext         {x, y}; x = plaintext[127:64]
//   busy              high from the cycle after start is accepted through done
//   done              one-cycle pulse, ciphertext valid in that cycle
//   ciphertext        final block, held until overwritten by the next result
//   round_start       one-cycle pulse launching the round unit
//   round_subkey      current subkey k_i, stable while the round unit works
//   round_plaintext   current block, stable while the round unit works
//   round_index       current round number i
//   round_finished    round-unit completion, sampled only while waiting
//   round_ciphertext  round-unit result, captured with round_finished
// ---------------------------------------------------------------------------
module speck_round_scheduler #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic         round_start,
    output logic [63:0]  round_subkey,
    output logic [127:0] round_plaintext,
    output logic [4:0]   round_index,
    input  logic         round_finished,
    input  logic [127:0] round_ciphertext
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [63:0] key_l;
    logic [63:0] next_l;
    logic [63:0] next_k;

    // The key schedule is the round function applied to (l, k) with the
    // round index standing in for the subkey. round_subkey is the k register
    // itself, and round_index is the pre-increment i the schedule needs.
    assign next_l = ({key_l[7:0], key_l[63:8]} + round_subkey) ^ {59'd0, round_index};
    assign next_k = {round_subkey[60:0], round_subkey[63:61]} ^ next_l;

    // Controller and datapath registers in one block, so every output is
    // registered and changes on the same edge as the state that implies it.
    // The idle load fills the block and key registers and raises round_start
    // for the first round. Each accepted round_finished captures the round
    // result, advances the key schedule, and then either re-issues or
    // finishes. The result is copied into ciphertext on the final
    // round_finished edge, so done and ciphertext appear together in the
    // DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            round_start     <= 1'b0;
            ciphertext      <= '0;
            round_subkey    <= '0;
            round_plaintext <= '0;
            round_index     <= '0;
            key_l           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        round_plaintext <= plaintext;
                        round_subkey    <= key[63:0];
                        key_l           <= key[127:64];
                        round_index     <= '0;
                        round_start     <= 1'b1;
                        busy            <= 1'b1;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    round_start <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (round_finished) begin
                        round_plaintext <= round_ciphertext;
                        key_l           <= next_l;
                        round_subkey    <= next_k;
                        if (round_index == LAST_ROUND) begin
                            ciphertext <= round_ciphertext;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            round_index <= round_index + 5'd1;
                            round_start <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speck_round_scheduler.sv
// ---------------------------------------------------------------------------
// tb_speck_round_scheduler
//
// Bench for speck_round_scheduler. A behavioural SPECK round unit with
// programmable latency answers the scheduler. Expected ciphertexts and done
// cycles are queued when a block is launched. A monitor pops them when done
// pulses. A second instance built with ROUNDS=1 covers the single-round case.
// ---------------------------------------------------------------------------
module tb_speck_round_scheduler;

    localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] KAT_CT  = 128'ha65d985179783265_7860fedf5c570d18;
    localparam logic [63:0]  KAT_K0  = 64'h0706050403020100;
    localparam logic [63:0]  KAT_K1  = 64'h37253b31171d0309;
    localparam logic [127:0] ALT_KEY = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] ALT_PT  = 128'hdeadbeefcafef00d_0011223344556677;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start1;
    logic         stray_finished;
    logic [127:0] key;
    logic [127:0] plaintext;

    logic         busy, done, round_start;
    logic [127:0] ciphertext, round_plaintext;
    logic [63:0]  round_subkey;
    logic [4:0]   round_index;
    logic         model_finished = 1'b0;
    logic [127:0] model_ct = '0;

    logic         busy1, done1, round_start1;
    logic [127:0] ciphertext1, round_plaintext1;
    logic [63:0]  round_subkey1;
    logic [4:0]   round_index1;
    logic         model1_finished = 1'b0;
    logic [127:0] model1_ct = '0;

    int lat = 1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int stab_viol = 0;
    int last_t0 = 0;

    typedef struct {
        logic [127:0] ct;
        int           t0;
        int           done_cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_cycle;

    logic [127:0] m_pt, m1_pt;
    logic [63:0]  m_k, m1_k, m_x, m_y, m1_x, m1_y;

    speck_round_scheduler #(.ROUNDS(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .key              (key),
        .plaintext        (plaintext),
        .busy             (busy),
        .done             (done),
        .ciphertext       (ciphertext),
        .round_start      (round_start),
        .round_subkey     (round_subkey),
        .round_plaintext  (round_plaintext),
        .round_index      (round_index),
        .round_finished   (model_finished | stray_finished),
        .round_ciphertext (model_ct)
    );

    speck_round_scheduler #(.ROUNDS(1)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .start            (start1),
        .key              (key),
        .plaintext        (plaintext),
        .busy             (busy1),
        .done             (done1),
        .ciphertext       (ciphertext1),
        .round_start      (round_start1),
        .round_subkey     (round_subkey1),
        .round_plaintext  (round_plaintext1),
        .round_index      (round_index1),
        .round_finished   (model1_finished),
        .round_ciphertext (model1_ct)
    );

    always #5 clk = ~clk;

    // Edge counter used to time events relative to the start-sampling edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ror8(input logic [63:0] v);
        return {v[7:0], v[63:8]};
    endfunction

    function automatic logic [63:0] rol3(input logic [63:0] v);
        return {v[60:0], v[63:61]};
    endfunction

    // Reference SPECK128/128 encryption over a given number of rounds.
    function automatic logic [127:0] speck_ref(input logic [127:0] k, input logic [127:0] p,
                                               input int rounds);
        logic [63:0] x, y, kk, ll;
        x  = p[127:64];
        y  = p[63:0];
        kk = k[63:0];
        ll = k[127:64];
        for (int r = 0; r < rounds; r++) begin
            x  = (ror8(x) + y) ^ kk;
            y  = rol3(y) ^ x;
            ll = (ror8(ll) + kk) ^ 64'(r);
            kk = rol3(kk) ^ ll;
        end
        return {x, y};
    endfunction

    // Round unit for the 32-round instance: latch inputs on round_start,
    // answer lat cycles later, and count any change of the presented
    // subkey/block while the round is outstanding. The result bus carries
    // junk outside the finished cycle, so a capture on the wrong edge is
    // caught.
    always begin
        @(negedge clk);
        if (round_start && !rst) begin
            m_pt = round_plaintext;
            m_k  = round_subkey;
            for (int n = 0; n < lat; n++) begin
                @(posedge clk);
                #1;
                if (busy && (round_plaintext !== m_pt || round_subkey !== m_k))
                    stab_viol++;
            end
            m_x = (ror8(m_pt[127:64]) + m_pt[63:0]) ^ m_k;
            m_y = rol3(m_pt[63:0]) ^ m_x;
            model_ct       = {m_x, m_y};
            model_finished = 1'b1;
            @(posedge clk);
            #1;
            model_finished = 1'b0;
            model_ct       = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Round unit for the single-round instance, fixed latency of one cycle.
    always begin
        @(negedge clk);
        if (round_start1 && !rst) begin
            m1_pt = round_plaintext1;
            m1_k  = round_subkey1;
            @(posedge clk);
            #1;
            m1_x = (ror8(m1_pt[127:64]) + m1_pt[63:0]) ^ m1_k;
            m1_y = rol3(m1_pt[63:0]) ^ m1_x;
            model1_ct       = {m1_x, m1_y};
            model1_finished = 1'b1;
            @(posedge clk);
            #1;
            model1_finished = 1'b0;
            model1_ct       = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Scoreboard monitor: every done pulse must match the oldest queued
    // expectation in both ciphertext and cycle number.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_done: done=1 with nothing pending, required 0");
            end else begin
                mon_e     = exp_q.pop_front();
                mon_cycle = cyc - mon_e.t0 + 1;
                checks++;
                if (ciphertext !== mon_e.ct) begin
                    errors++;
                    $display("[TB] FAIL ciphertext: got %h required %h", ciphertext, mon_e.ct);
                end
                checks++;
                if (mon_cycle !== mon_e.done_cycle) begin
                    errors++;
                    $display("[TB] FAIL done_cycle: got %0d required %0d", mon_cycle, mon_e.done_cycle);
                end
            end
        end
    end

    // Called at a negedge with the scheduler idle: drives a one-cycle start
    // and queues the expectation. Returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p,
                                 input logic [127:0] exp_ct, input int exp_cycle);
        key       = k;
        plaintext = p;
        start     = 1'b1;
        last_t0   = cyc + 1;
        exp_q.push_back('{exp_ct, last_t0, exp_cycle});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL done_timeout: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic waitCycle(input int c);
        for (int n = 0; n < 400 && cyc < last_t0 + c - 1; n++) @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, round_start, round_index} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b required 0", {busy, done, round_start, round_index});
        end
        checks++;
        if ({ciphertext, round_subkey, round_plaintext} !== 320'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h required 0", {ciphertext, round_subkey, round_plaintext});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_kat(input int l);
        int found;
        $display("[TB] test_kat latency %0d", l);
        lat       = l;
        stab_viol = 0;
        applyStimulus(KAT_KEY, KAT_PT, KAT_CT, 32 * (l + 1) + 1);
        checks++;
        if (!(round_start && round_index == 5'd0 && round_subkey === KAT_K0
              && round_plaintext === KAT_PT)) begin
            errors++;
            $display("[TB] FAIL round0: start=%b idx=%0d subkey=%h pt=%h required 1 0 %h %h",
                     round_start, round_index, round_subkey, round_plaintext, KAT_K0, KAT_PT);
        end
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (round_start && round_index == 5'd1) found = 1;
        end
        checks++;
        if (found == 0 || round_subkey !== KAT_K1) begin
            errors++;
            $display("[TB] FAIL round1_subkey: got %h required %h", round_subkey, KAT_K1);
        end
        waitDone(400);
        checks++;
        if (stab_viol !== 0) begin
            errors++;
            $display("[TB] FAIL round_stable: changes=%0d required 0", stab_viol);
        end
    endtask

    task automatic test_start_ignored();
        $display("[TB] test_start_ignored");
        lat = 1;
        applyStimulus(KAT_KEY, KAT_PT, KAT_CT, 65);
        waitCycle(10);
        key       = ALT_KEY;
        plaintext = ALT_PT;
        start     = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        stray_finished = 1'b1;
        @(negedge clk);
        stray_finished = 1'b0;
        waitCycle(64);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        waitDone(200);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_ignored_idle: busy=%b required 0", busy);
        end
        key       = KAT_KEY;
        plaintext = KAT_PT;
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        lat = 1;
        applyStimulus(KAT_KEY, KAT_PT, KAT_CT, 65);
        waitCycle(20);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({busy, done, round_start, round_index, ciphertext, round_subkey, round_plaintext} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: busy=%b done=%b rs=%b idx=%0d ct=%h sk=%h pt=%h required 0",
                     busy, done, round_start, round_index, ciphertext, round_subkey, round_plaintext);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        stray_finished = 1'b1;
        @(negedge clk);
        stray_finished = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, round_start, round_subkey, round_plaintext} !== '0) begin
            errors++;
            $display("[TB] FAIL stray_finished: busy=%b rs=%b sk=%h pt=%h required 0",
                     busy, round_start, round_subkey, round_plaintext);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp2;
        int           hold_bad;
        int           seen;
        $display("[TB] test_back_to_back");
        lat  = 2;
        exp2 = speck_ref(ALT_KEY, ALT_PT, 32);
        applyStimulus(KAT_KEY, KAT_PT, KAT_CT, 97);
        seen = 0;
        for (int n = 0; n < 200 && seen == 0; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        @(negedge clk);
        applyStimulus(ALT_KEY, ALT_PT, exp2, 97);
        hold_bad = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            if (ciphertext !== KAT_CT) hold_bad++;
            @(negedge clk);
        end
        checks++;
        if (seen == 0 || hold_bad != 0) begin
            errors++;
            $display("[TB] FAIL ct_hold: first_done=%0d changes=%0d required 1 0", seen, hold_bad);
        end
        waitDone(50);
    endtask

    task automatic test_rounds1();
        logic [127:0] exp1;
        int           pulses;
        int           done_at;
        int           t0;
        logic [127:0] got;
        $display("[TB] test_rounds1");
        exp1      = speck_ref(KAT_KEY, KAT_PT, 1);
        key       = KAT_KEY;
        plaintext = KAT_PT;
        start1    = 1'b1;
        t0        = cyc + 1;
        pulses    = 0;
        done_at   = -1;
        got       = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (round_start1) pulses++;
            if (done1) begin
                done_at = cyc - t0 + 1;
                got     = ciphertext1;
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL r1_pulses: got %0d required 1", pulses);
        end
        checks++;
        if (done_at != 3) begin
            errors++;
            $display("[TB] FAIL r1_done_cycle: got %0d required 3", done_at);
        end
        checks++;
        if (got !== exp1) begin
            errors++;
            $display("[TB] FAIL r1_ciphertext: got %h required %h", got, exp1);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        start1         = 1'b0;
        stray_finished = 1'b0;
        key            = '0;
        plaintext      = '0;
        test_reset();
        test_kat(1);
        test_kat(5);
        test_start_ignored();
        test_reset_mid();
        test_kat(1);
        test_back_to_back();
        test_rounds1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
